// File: rtl/legal_move_checker_if.sv
// Bus between the position datapath / maze memory and legal_move_checker.
//   master : requester side (datapath + maze memory model)
//            drives start, changedX/Y, tempCurrentX/Y, mem_q
//   slave  : the checker itself
//            drives mem_addr, doneLegal, isLegal, score flags, gameOver, busy
interface legal_move_checker_if #(
    parameter int COORD_W = 5
);
    logic                   start;
    logic [COORD_W-1:0]     changedX;
    logic [COORD_W-1:0]     changedY;
    logic [COORD_W-1:0]     tempCurrentX;
    logic [COORD_W-1:0]     tempCurrentY;
    logic [2:0]             mem_q;
    logic [2*COORD_W-1:0]   mem_addr;
    logic                   doneLegal;
    logic                   isLegal;
    logic                   scorePlusFive;
    logic                   scoreMinusFive;
    logic                   gameOver;
    logic                   busy;

    modport master (
        output start, changedX, changedY, tempCurrentX, tempCurrentY, mem_q,
        input  mem_addr, doneLegal, isLegal, scorePlusFive, scoreMinusFive,
               gameOver, busy
    );

    modport slave (
        input  start, changedX, changedY, tempCurrentX, tempCurrentY, mem_q,
        output mem_addr, doneLegal, isLegal, scorePlusFive, scoreMinusFive,
               gameOver, busy
    );
endinterface

// File: rtl/legal_move_checker.sv
// Validates one candidate move against the board bounds, the current
// position and the maze memory, and reports legality / score tiles / exit.
// Ports:
//   clock   in   system clock, rising edge
//   resetn  in   asynchronous active-low reset
//   bus     slave modport of legal_move_checker_if (request, memory, results)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; fast-path results are issued from here
// READ  | mem_addr presented; load wait counter
// WAIT  | counting down remaining memory latency
// EVAL  | mem_q valid; register result and pulse doneLegal
module legal_move_checker #(
    parameter int COORD_W     = 5,
    parameter int MAX_COL     = 19,
    parameter int MAX_ROW     = 14,
    parameter int ROM_LATENCY = 2
) (
    input  logic               clock,
    input  logic               resetn,
    legal_move_checker_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_WAIT = 2'd2,
        S_EVAL = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [2*COORD_W-1:0]   mem_addr_q, mem_addr_d;
    logic                   done_q, done_d;
    logic                   legal_q, legal_d;
    logic                   plus_q, plus_d;
    logic                   minus_q, minus_d;
    logic                   game_over_q, game_over_d;
    logic                   busy_q, busy_d;

    logic off_board;
    logic same_pos;
    logic need_read;

    // Decrementing 0 wraps to all-ones, which lands above the max and is
    // rejected here along with any genuine off-board coordinate.
    assign off_board = (bus.changedX > COORD_W'(MAX_COL)) ||
                       (bus.changedY > COORD_W'(MAX_ROW));
    assign same_pos  = (bus.changedX == bus.tempCurrentX) &&
                       (bus.changedY == bus.tempCurrentY);
    assign need_read = bus.start && !game_over_q && !off_board && !same_pos;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            done_q      <= 1'b0;
            legal_q     <= 1'b0;
            plus_q      <= 1'b0;
            minus_q     <= 1'b0;
            game_over_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            done_q      <= done_d;
            legal_q     <= legal_d;
            plus_q      <= plus_d;
            minus_q     <= minus_d;
            game_over_q <= game_over_d;
            busy_q      <= busy_d;
        end
    end

    // Results are registered on the edge that leaves EVAL, so doneLegal
    // lands ROM_LATENCY+2 cycles after start. READ itself covers one cycle
    // of latency, hence WAIT exits when the counter is about to reach 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (need_read) state_d = S_READ;
            end
            S_READ: begin
                cnt_d = 3'(ROM_LATENCY - 1);
                if (ROM_LATENCY <= 1) state_d = S_EVAL;
                else                  state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) state_d = S_EVAL;
            end
            S_EVAL: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        done_d      = 1'b0;
        legal_d     = legal_q;
        plus_d      = plus_q;
        minus_d     = minus_q;
        game_over_d = game_over_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    legal_d = 1'b0;
                    plus_d  = 1'b0;
                    minus_d = 1'b0;
                    if (game_over_q || off_board) begin
                        done_d = 1'b1;
                    end else if (same_pos) begin
                        done_d  = 1'b1;
                        legal_d = 1'b1;
                    end else begin
                        mem_addr_d = {bus.changedY, bus.changedX};
                        busy_d     = 1'b1;
                    end
                end
            end
            S_EVAL: begin
                legal_d     = (bus.mem_q >= 3'd1) && (bus.mem_q <= 3'd4);
                plus_d      = (bus.mem_q == 3'd2);
                minus_d     = (bus.mem_q == 3'd3);
                game_over_d = game_over_q || (bus.mem_q == 3'd4);
                done_d      = 1'b1;
                busy_d      = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr       = mem_addr_q;
    assign bus.doneLegal      = done_q;
    assign bus.isLegal        = legal_q;
    assign bus.scorePlusFive  = plus_q;
    assign bus.scoreMinusFive = minus_q;
    assign bus.gameOver       = game_over_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_legal_move_checker.sv
module tb_legal_move_checker;
    localparam int COORD_W     = 5;
    localparam int MAX_COL     = 19;
    localparam int MAX_ROW     = 14;
    localparam int ROM_LATENCY = 2;

    logic clock = 1'b0;
    logic resetn = 1'b1;
    always #5 clock = ~clock;

    legal_move_checker_if #(.COORD_W(COORD_W)) bus ();

    legal_move_checker #(
        .COORD_W(COORD_W), .MAX_COL(MAX_COL), .MAX_ROW(MAX_ROW),
        .ROM_LATENCY(ROM_LATENCY)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .bus(bus)
    );

    // Maze memory: registered read with ROM_LATENCY = 2 cycles.
    logic [2:0] maze [0:1023];
    logic [2:0] q_pipe;
    always @(posedge clock) begin
        q_pipe     <= maze[bus.mem_addr];
        bus.mem_q  <= q_pipe;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit         m_go;
    logic [9:0] m_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {20'd0, bus.mem_addr, bus.doneLegal, bus.isLegal,
                bus.scorePlusFive, bus.scoreMinusFive, bus.gameOver, bus.busy};
    endfunction

    task automatic apply_reset(input string tag);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check_eq({tag, "_outs"}, out_vec(), 32'd0);
        m_go   = 1'b0;
        m_addr = '0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // One request, checked against the rules of the game.
    task automatic do_move(input string tag, input int x, input int y, input int cx, input int cy);
        int exp_lat;
        int lat;
        bit e_legal, e_plus, e_minus;
        int code;
        e_legal = 0; e_plus = 0; e_minus = 0; exp_lat = 1;
        if (m_go) begin
            e_legal = 0;
        end else if (x > MAX_COL || y > MAX_ROW) begin
            e_legal = 0;
        end else if (x == cx && y == cy) begin
            e_legal = 1;
        end else begin
            code    = int'(maze[y * 32 + x]);
            e_legal = (code >= 1 && code <= 4);
            e_plus  = (code == 2);
            e_minus = (code == 3);
            if (code == 4) m_go = 1;
            exp_lat = ROM_LATENCY + 2;
            m_addr  = 10'(y * 32 + x);
        end

        @(negedge clock);
        bus.changedX     = 5'(x);
        bus.changedY     = 5'(y);
        bus.tempCurrentX = 5'(cx);
        bus.tempCurrentY = 5'(cy);
        bus.start        = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.doneLegal && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_isLegal"}, bus.isLegal, e_legal);
        check_eq({tag, "_plus"}, bus.scorePlusFive, e_plus);
        check_eq({tag, "_minus"}, bus.scoreMinusFive, e_minus);
        check_eq({tag, "_gameOver"}, bus.gameOver, m_go);
        check_eq({tag, "_mem_addr"}, bus.mem_addr, m_addr);
        check_eq({tag, "_busy"}, bus.busy, 1'b0);
        @(negedge clock);
        check_eq({tag, "_done_once"}, bus.doneLegal, 1'b0);
        check_eq({tag, "_hold"}, bus.isLegal, e_legal);
    endtask

    initial begin
        int dones;
        int x, y, cx, cy;
        bus.start = 1'b0;
        bus.changedX = '0; bus.changedY = '0;
        bus.tempCurrentX = '0; bus.tempCurrentY = '0;
        for (int i = 0; i < 1024; i++) maze[i] = 3'($urandom_range(0, 7));
        m_go = 0; m_addr = '0;

        apply_reset("reset");

        // Basic memory path
        maze[4 * 32 + 3] = 3'd1;
        do_move("t1", 3, 4, 2, 4);
        check_eq("t1_addr_083", bus.mem_addr, 10'h083);

        // Cell codes at (5,5)
        maze[5 * 32 + 5] = 3'd0; do_move("t2_wall", 5, 5, 5, 4);
        maze[5 * 32 + 5] = 3'd2; do_move("t2_bonus", 5, 5, 5, 4);
        maze[5 * 32 + 5] = 3'd3; do_move("t2_penalty", 5, 5, 5, 4);
        maze[5 * 32 + 5] = 3'd6; do_move("t2_code6", 5, 5, 4, 5);

        // Off-board and no-move fast paths
        do_move("t3_x31", 31, 2, 0, 2);
        do_move("t3_y15", 2, 15, 2, 14);
        do_move("t3_edge", 19, 14, 18, 14);
        do_move("same_pos", 7, 7, 7, 7);

        // Exit tile, then sticky gameOver
        maze[9 * 32 + 9] = 3'd4;
        do_move("t4_exit", 9, 9, 8, 9);
        do_move("t4_after", 3, 4, 2, 4);
        do_move("t4_after_same", 3, 3, 3, 3);
        apply_reset("t4_reset");

        // Second start while busy is dropped
        maze[6 * 32 + 6] = 3'd2;
        maze[7 * 32 + 7] = 3'd0;
        @(negedge clock);
        bus.changedX = 5'd6; bus.changedY = 5'd6;
        bus.tempCurrentX = 5'd5; bus.tempCurrentY = 5'd6;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        bus.changedX = 5'd7; bus.changedY = 5'd7;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.doneLegal) begin
                dones++;
                check_eq("t5_isLegal", bus.isLegal, 1'b1);
                check_eq("t5_plus", bus.scorePlusFive, 1'b1);
                check_eq("t5_addr", bus.mem_addr, 10'(6 * 32 + 6));
            end
            @(negedge clock);
        end
        check_eq("t5_done_count", dones, 1);
        m_addr = 10'(6 * 32 + 6);

        // Reset while in WAIT
        @(negedge clock);
        bus.changedX = 5'd3; bus.changedY = 5'd4;
        bus.tempCurrentX = 5'd2; bus.tempCurrentY = 5'd4;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        check_eq("t6_busy_before", bus.busy, 1'b1);
        resetn = 1'b0;
        #1;
        check_eq("t6_outs", out_vec(), 32'd0);
        m_go = 0; m_addr = '0;
        @(negedge clock);
        resetn = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (bus.doneLegal) dones++;
        end
        check_eq("t6_no_done", dones, 0);
        maze[4 * 32 + 3] = 3'd3;
        do_move("t6_next", 3, 4, 2, 4);

        // Randomized moves
        for (int n = 0; n < 60; n++) begin
            if (m_go && ($urandom_range(0, 1) == 1)) apply_reset("rnd_reset");
            x  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, MAX_COL));
            y  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, MAX_ROW));
            cx = int'($urandom_range(0, MAX_COL));
            cy = int'($urandom_range(0, MAX_ROW));
            if ($urandom_range(0, 7) == 0) begin
                cx = x; cy = y;
            end
            do_move("rnd", x, y, cx, cy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
